// File: rtl/aes_pkg.sv
// Shared AES front-end definitions: key-size encodings, command key codes,
// loader FSM states and the key-length helper.
package aes_pkg;

  localparam logic [2:0] KS_128 = 3'b001;
  localparam logic [2:0] KS_192 = 3'b010;
  localparam logic [2:0] KS_256 = 3'b100;

  localparam logic [1:0] KC_128     = 2'b00;
  localparam logic [1:0] KC_192     = 2'b01;
  localparam logic [1:0] KC_256     = 2'b10;
  localparam logic [1:0] KC_ILLEGAL = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    KEY,
    MSG,
    START,
    BUSY
  } state_e;

  function automatic logic [5:0] key_bytes(input logic [1:0] code);
    case (code)
      KC_192:  return 6'd24;
      KC_256:  return 6'd32;
      default: return 6'd16;
    endcase
  endfunction

  function automatic logic [4:0] key_last_idx(input logic [1:0] code);
    return 5'(key_bytes(code) - 6'd1);
  endfunction

  function automatic logic [2:0] key_size_onehot(input logic [1:0] code);
    case (code)
      KC_192:  return KS_192;
      KC_256:  return KS_256;
      default: return KS_128;
    endcase
  endfunction

endpackage

// File: rtl/aes_ingress_loader.sv
// Byte-serial ingress for the AES core: command, key and message bytes are
// assembled into the core's parallel inputs, then a start pulse is issued.
module aes_ingress_loader
  import aes_pkg::*;
#(
  parameter int MSG_BYTES     = 16,
  parameter int KEY_MAX_BYTES = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       core_done,
  output logic                       core_start,
  output logic                       core_enc_or_dec,
  output logic [2:0]                 core_key_size,
  output logic [8*KEY_MAX_BYTES-1:0] core_key,
  output logic [8*MSG_BYTES-1:0]     core_msg,
  output logic                       busy,
  output logic                       cmd_err
);

  state_e                     state_q, state_d;
  logic [4:0]                 byte_cnt_q, byte_cnt_d;
  logic [1:0]                 key_code_q, key_code_d;
  logic                       in_ready_q, in_ready_d;
  logic                       core_start_q, core_start_d;
  logic                       enc_q, enc_d;
  logic [2:0]                 key_size_q, key_size_d;
  logic [8*KEY_MAX_BYTES-1:0] key_q, key_d;
  logic [8*MSG_BYTES-1:0]     msg_q, msg_d;
  logic                       busy_q, busy_d;
  logic                       cmd_err_q, cmd_err_d;

  logic xfer;
  logic cmd_legal;
  logic key_last;
  logic msg_last;

  assign xfer      = in_valid & in_ready_q;
  assign cmd_legal = (in_data[2:1] != KC_ILLEGAL);
  assign key_last  = (byte_cnt_q == key_last_idx(key_code_q));
  assign msg_last  = (byte_cnt_q == 5'(MSG_BYTES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      byte_cnt_q   <= '0;
      key_code_q   <= KC_128;
      in_ready_q   <= 1'b0;
      core_start_q <= 1'b0;
      enc_q        <= 1'b0;
      key_size_q   <= KS_128;
      key_q        <= '0;
      msg_q        <= '0;
      busy_q       <= 1'b0;
      cmd_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      key_code_q   <= key_code_d;
      in_ready_q   <= in_ready_d;
      core_start_q <= core_start_d;
      enc_q        <= enc_d;
      key_size_q   <= key_size_d;
      key_q        <= key_d;
      msg_q        <= msg_d;
      busy_q       <= busy_d;
      cmd_err_q    <= cmd_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (xfer && cmd_legal) state_d = KEY;
      KEY:     if (xfer && key_last)  state_d = MSG;
      MSG:     if (xfer && msg_last)  state_d = START;
      START:   state_d = BUSY;
      BUSY:    if (core_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Byte 0 lands in the most significant byte, so the wide words read in
  // arrival order from the MSB down.
  always_comb begin
    byte_cnt_d = byte_cnt_q;
    key_code_d = key_code_q;
    enc_d      = enc_q;
    key_size_d = key_size_q;
    key_d      = key_q;
    msg_d      = msg_q;
    cmd_err_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          if (cmd_legal) begin
            enc_d      = in_data[0];
            key_code_d = in_data[2:1];
            key_size_d = key_size_onehot(in_data[2:1]);
            key_d      = '0;
            byte_cnt_d = '0;
          end else begin
            cmd_err_d = 1'b1;
          end
        end
      end
      KEY: begin
        if (xfer) begin
          for (int i = 0; i < KEY_MAX_BYTES; i++) begin
            if (byte_cnt_q == 5'(i)) key_d[8*KEY_MAX_BYTES-1-8*i -: 8] = in_data;
          end
          byte_cnt_d = key_last ? 5'd0 : byte_cnt_q + 5'd1;
        end
      end
      MSG: begin
        if (xfer) begin
          for (int i = 0; i < MSG_BYTES; i++) begin
            if (byte_cnt_q == 5'(i)) msg_d[8*MSG_BYTES-1-8*i -: 8] = in_data;
          end
          byte_cnt_d = msg_last ? 5'd0 : byte_cnt_q + 5'd1;
        end
      end
      default: ;
    endcase
    in_ready_d   = (state_d == IDLE) || (state_d == KEY) || (state_d == MSG);
    core_start_d = (state_d == START);
    busy_d       = (state_d == START) || (state_d == BUSY);
  end

  assign in_ready        = in_ready_q;
  assign core_start      = core_start_q;
  assign core_enc_or_dec = enc_q;
  assign core_key_size   = key_size_q;
  assign core_key        = key_q;
  assign core_msg        = msg_q;
  assign busy            = busy_q;
  assign cmd_err         = cmd_err_q;

endmodule

// File: tb/tb_aes_ingress_loader.sv
// Directed bench for the AES ingress loader: table-driven block loads plus
// hand sequences for illegal commands and mid-load reset.
module tb_aes_ingress_loader;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_ready;
  logic         core_done;
  logic         core_start;
  logic         core_enc_or_dec;
  logic [2:0]   core_key_size;
  logic [255:0] core_key;
  logic [127:0] core_msg;
  logic         busy;
  logic         cmd_err;

  int n_checks = 0;
  int n_fail   = 0;
  int start_cnt = 0;

  typedef struct {
    logic [7:0]   cmd;
    int           nkey;
    logic [255:0] key_src;
    logic [127:0] msg;
    logic [255:0] exp_key;
    logic [2:0]   exp_ks;
    logic         exp_enc;
    int           hold;
    bit           gaps;
  } vec_t;

  vec_t vecs[4];

  always #5 clk = ~clk;

  always @(negedge clk) if (core_start === 1'b1) start_cnt++;

  aes_ingress_loader dut (
    .clk             (clk),
    .rst             (rst),
    .in_data         (in_data),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .core_done       (core_done),
    .core_start      (core_start),
    .core_enc_or_dec (core_enc_or_dec),
    .core_key_size   (core_key_size),
    .core_key        (core_key),
    .core_msg        (core_msg),
    .busy            (busy),
    .cmd_err         (cmd_err)
  );

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 right after the transfer edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int waited;
    repeat (gap) begin
      @(posedge clk); #1;
    end
    in_data  = b;
    in_valid = 1'b1;
    waited   = 0;
    forever begin
      @(negedge clk);
      if (in_ready === 1'b1) break;
      waited++;
      if (waited > 100) begin
        n_checks++;
        n_fail++;
        $display("FAIL send_timeout: in_ready stuck at %b for byte %h, required 1", in_ready, b);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run_block(input int k);
    vec_t v;
    int   s0;
    int   cyc;
    int   exp_cyc;
    v  = vecs[k];
    s0 = start_cnt;
    send_byte(v.cmd, v.gaps ? int'($urandom_range(0, 2)) : 0);
    for (int i = 0; i < v.nkey; i++)
      send_byte(v.key_src[255-8*i -: 8], v.gaps ? int'($urandom_range(0, 3)) : 0);
    for (int i = 0; i < 16; i++)
      send_byte(v.msg[127-8*i -: 8], v.gaps ? int'($urandom_range(0, 3)) : 0);
    check($sformatf("blk%0d_start", k), {255'd0, core_start}, 256'd1);
    check($sformatf("blk%0d_busy", k), {255'd0, busy}, 256'd1);
    check($sformatf("blk%0d_ready", k), {255'd0, in_ready}, 256'd0);
    check($sformatf("blk%0d_key", k), core_key, v.exp_key);
    check($sformatf("blk%0d_msg", k), {128'd0, core_msg}, {128'd0, v.msg});
    check($sformatf("blk%0d_ks", k), {253'd0, core_key_size}, {253'd0, v.exp_ks});
    check($sformatf("blk%0d_enc", k), {255'd0, core_enc_or_dec}, {255'd0, v.exp_enc});
    // Upstream keeps offering a byte while the loader is busy; it must not be taken.
    in_valid = 1'b1;
    in_data  = 8'h00;
    for (int c = 0; c < v.hold; c++) begin
      @(posedge clk); #1;
      check($sformatf("blk%0d_hold_stat", k),
            {249'd0, core_start, busy, in_ready, core_key_size, core_enc_or_dec},
            {249'd0, 1'b0, 1'b1, 1'b0, v.exp_ks, v.exp_enc});
      check($sformatf("blk%0d_hold_data", k), core_key ^ {128'd0, core_msg},
            v.exp_key ^ {128'd0, v.msg});
    end
    in_valid  = 1'b0;
    core_done = 1'b1;
    cyc = 0;
    while (busy === 1'b1 && cyc < 4) begin
      @(posedge clk); #1;
      cyc++;
    end
    core_done = 1'b0;
    exp_cyc = (v.hold == 0) ? 2 : 1;
    check($sformatf("blk%0d_done_lat", k), 256'(cyc), 256'(exp_cyc));
    check($sformatf("blk%0d_idle", k), {254'd0, busy, in_ready}, {254'd0, 2'b01});
    check($sformatf("blk%0d_npulse", k), 256'(start_cnt - s0), 256'd1);
    check($sformatf("blk%0d_key_kept", k), core_key, v.exp_key);
  endtask

  initial begin
    vecs[0] = '{8'h00, 16,
                256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                256'h000102030405060708090a0b0c0d0e0f00000000000000000000000000000000,
                3'b001, 1'b0, 3, 1'b0};
    vecs[1] = '{8'h05, 32,
                256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                128'h00112233445566778899aabbccddeeff,
                256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                3'b100, 1'b1, 40, 1'b0};
    vecs[2] = '{8'hf9, 16,
                256'h2b7e151628aed2a6abf7158809cf4f3cffffffffffffffffffffffffffffffff,
                128'h6bc1bee22e409f96e93d7e117393172a,
                256'h2b7e151628aed2a6abf7158809cf4f3c00000000000000000000000000000000,
                3'b001, 1'b1, 2, 1'b0};
    vecs[3] = '{8'h02, 24,
                256'ha0a1a2a3a4a5a6a7a8a9aaabacadaeafb0b1b2b3b4b5b6b75555555555555555,
                128'hf0e0d0c0b0a090807060504030201000,
                256'ha0a1a2a3a4a5a6a7a8a9aaabacadaeafb0b1b2b3b4b5b6b70000000000000000,
                3'b010, 1'b0, 0, 1'b1};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    core_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_status", {247'd0, in_ready, core_start, core_enc_or_dec, core_key_size, busy, cmd_err},
          {247'd0, 1'b0, 1'b0, 1'b0, 3'b001, 1'b0, 1'b0});
    check("rst_key", core_key, 256'd0);
    check("rst_msg", {128'd0, core_msg}, 256'd0);
    rst = 1'b0;
    check("ready_before_edge", {255'd0, in_ready}, 256'd0);
    @(posedge clk); #1;
    check("ready_after_edge", {255'd0, in_ready}, 256'd1);

    // Blocks run back to back: each command follows the cycle busy drops.
    for (int k = 0; k < 4; k++) run_block(k);

    send_byte(8'h06, 0);
    check("illegal_err", {255'd0, cmd_err}, 256'd1);
    check("illegal_idle", {254'd0, busy, in_ready}, {254'd0, 2'b01});
    check("illegal_key", core_key, vecs[3].exp_key);
    check("illegal_ks", {253'd0, core_key_size}, {253'd0, 3'b010});
    @(posedge clk); #1;
    check("illegal_err_clr", {255'd0, cmd_err}, 256'd0);
    send_byte(8'hfe, 0);
    check("illegal2_err", {255'd0, cmd_err}, 256'd1);
    @(posedge clk); #1;
    run_block(0);

    send_byte(8'h05, 0);
    for (int i = 0; i < 10; i++) send_byte(8'hee, 0);
    check("partial_key", {176'd0, core_key[255:176]}, {176'd0, {10{8'hee}}});
    check("partial_ks", {253'd0, core_key_size}, {253'd0, 3'b100});
    #2;
    rst = 1'b1;
    #1;
    check("midrst_status", {247'd0, in_ready, core_start, core_enc_or_dec, core_key_size, busy, cmd_err},
          {247'd0, 1'b0, 1'b0, 1'b0, 3'b001, 1'b0, 1'b0});
    check("midrst_key", core_key, 256'd0);
    check("midrst_msg", {128'd0, core_msg}, 256'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_block(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation time %0t exceeded, required completion earlier", $time);
    $fatal(1, "timeout");
  end

endmodule
